// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared memory types and the port tag used by the CPU/DMA memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mw_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_t;

    localparam int MEM_ARB_MAX_WAIT_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module : mem_arbiter_if
// Brief  : Requester-side access bus (request, grant, tagged read return).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic  req;
    mw_t   mw;
    addr_t addr;
    data_t wdata;
    logic  gnt;
    logic  rvalid;
    data_t rdata;

    modport master (
        output req, mw, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, mw, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_wait_guard.sv
// ============================================================================
// Module : mem_arbiter_wait_guard
// Brief  : Counts consecutive lost DMA cycles and forces a DMA grant at MAX_WAIT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter_wait_guard #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic dma_req_i,
    input  wire logic dma_gnt_i,
    output logic      dma_force_o
);

    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] c_ONE      = {{(WAIT_W-1){1'b0}}, 1'b1};

    logic [WAIT_W-1:0] dma_wait_q;
    logic [WAIT_W-1:0] dma_wait_d;

    // Saturate rather than wrap so a stuck count can never fall back below the threshold.
    always_comb begin
        dma_wait_d = dma_wait_q;
        if (!dma_req_i || dma_gnt_i) begin
            dma_wait_d = '0;
        end else if (dma_wait_q != '1) begin
            dma_wait_d = dma_wait_q + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dma_wait_q <= '0;
        end else begin
            dma_wait_q <= dma_wait_d;
        end
    end

    assign dma_force_o = dma_req_i && (dma_wait_q == c_MAX_WAIT);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : CPU/DMA arbiter for the single-port cpumemory; CPU priority, tagged
//          one-cycle read return. MEM_ARB_WAIT_GUARD_EN enables DMA anti-starvation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MEM_ARB_MAX_WAIT_DEFAULT,
    parameter int WAIT_W   = 8
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave cpu,
    mem_arbiter_if.slave dma,
    output mw_t          mem_mw,
    output addr_t        mem_addr,
    output data_t        mem_wdata,
    input  wire data_t   mem_rdata
);

    logic  w_dma_force;
    logic  w_cpu_gnt;
    logic  w_dma_gnt;
    logic  rd_pend_q;
    logic  rd_pend_d;
    port_t rd_port_q;
    port_t rd_port_d;

`ifdef MEM_ARB_WAIT_GUARD_EN
    mem_arbiter_wait_guard #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_guard (
        .clk         (clk),
        .reset       (reset),
        .dma_req_i   (dma.req),
        .dma_gnt_i   (w_dma_gnt),
        .dma_force_o (w_dma_force)
    );
`else
    // Strict CPU priority; the expression is constant 0 for any legal parameter set.
    assign w_dma_force = (MAX_WAIT < 0) && (WAIT_W < 0);
`endif

    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!reset) begin
            if (dma.req && (w_dma_force || !cpu.req)) begin
                w_dma_gnt = 1'b1;
            end else if (cpu.req) begin
                w_cpu_gnt = 1'b1;
            end
        end
    end

    // Idle cycles present a harmless read of address 0.
    always_comb begin
        mem_mw    = READ;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_mw    = cpu.mw;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
        end else if (w_dma_gnt) begin
            mem_mw    = dma.mw;
            mem_addr  = dma.addr;
            mem_wdata = dma.wdata;
        end
    end

    always_comb begin
        rd_pend_d = (w_cpu_gnt && (cpu.mw == READ)) || (w_dma_gnt && (dma.mw == READ));
        rd_port_d = w_dma_gnt ? PORT_DMA : PORT_CPU;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= PORT_CPU;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    assign cpu.gnt    = w_cpu_gnt;
    assign dma.gnt    = w_dma_gnt;
    // Gating with reset drops a read whose return would land in a reset cycle.
    assign cpu.rvalid = rd_pend_q && !reset && (rd_port_q == PORT_CPU);
    assign dma.rvalid = rd_pend_q && !reset && (rd_port_q == PORT_DMA);
    assign cpu.rdata  = mem_rdata;
    assign dma.rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester access arbiter in front of the single-port cpumemory (64K x data_t, synchronous read, one-cycle read latency).
- Requester 0 is the 6502 core (cpu_*); requester 1 is a DMA/loader port (dma_*), e.g. UART ROM loader or video fetch.
- Issues at most one memory access per cycle, returns read data tagged to the issuing port, and prevents DMA starvation.

Parameters:
- MAX_WAIT, 8, max consecutive cycles a pending DMA request loses before it is forced through (1..255).
- WAIT_W, 8, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_mw  in  mw_t  READ/WRITE
- cpu_addr  in  addr_t  address
- cpu_wdata  in  data_t  write data
- cpu_gnt  out  1  access accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid (registered)
- cpu_rdata  out  data_t  read data
- dma_req, dma_mw, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as cpu_* for DMA port
- mem_mw  out  mw_t  to cpumemory mw
- mem_addr  out  addr_t  to cpumemory addr
- mem_wdata  out  data_t  to cpumemory data_in
- mem_rdata  in  data_t  from cpumemory data_out

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Handshake:
  - A request is consumed on a cycle where req=1 and gnt=1.
  - Requesters hold mw/addr/wdata stable while req=1 and not granted.
  - gnt is never asserted without req.
  - Back-to-back grants to the same port on consecutive cycles are allowed.
- Arbitration (combinational, per cycle):
  - At most one of cpu_gnt/dma_gnt is high.
  - Default is fixed priority, CPU over DMA.
  - If the guard is active (see Optional Feature), DMA wins that cycle.
- Memory drive (combinational mux of the winner):
  - mem_mw/mem_addr/mem_wdata follow the winner's inputs.
  - With no grant: mem_mw=READ, mem_addr=0, mem_wdata=0, so an idle cycle is a harmless read.
- Read return:
  - A granted READ in cycle N sets a one-bit tag register (rd_pend, rd_port).
  - In cycle N+1, the tagged port's rvalid=1 and its rdata=mem_rdata. The other port's rvalid=0.
  - rdata is passed through combinationally from mem_rdata; it is don't-care when rvalid=0.
  - A granted WRITE produces no rvalid.
  - Pipelined: a read grant in N+1 overlaps the return of N; both complete correctly.
- Reset:
  - cpu_gnt=dma_gnt=0 while reset=1, and mem_* are at idle values.
  - rd_pend clears, so cpu_rvalid=dma_rvalid=0 in the cycle after reset is asserted.
  - A read granted in the cycle before reset is dropped; no rvalid.
  - Wait counter clears to 0.
- Simultaneous events: with both req=1 in the same cycle, exactly one grant follows the priority rule; the loser keeps req high.
- A write followed next cycle by a read of the same address returns the new data; this is a memory property, and the arbiter inserts no bubble.

Optional Feature:
- Macro: MEM_ARB_WAIT_GUARD_EN.
- Defined:
  - WAIT_W-bit counter dma_wait increments each cycle with dma_req=1 and dma_gnt=0; it clears on dma_gnt or when dma_req=0.
  - When dma_wait==MAX_WAIT, DMA is granted that cycle even if cpu_req=1, and the CPU waits.
  - The counter saturates and never wraps.
- Undefined:
  - Strict CPU priority; no counter is instantiated.
  - DMA may starve indefinitely.

Decomposition:
- Reuse common_types::addr_t, data_t, mw_t (READ/WRITE).
- Add to common_types: typedef enum logic {PORT_CPU, PORT_DMA} port_t; and localparam MEM_ARB_MAX_WAIT_DEFAULT=8.
- No sub-module needed. Optionally split out mem_arb_wait_guard (the counter) so the `ifdef wraps one instance.

Test Plan:
- Reset: hold reset 3 cycles with cpu_req=dma_req=1 -> both gnt=0, both rvalid=0, mem_mw=READ, mem_addr=0.
- CPU read: preload mem[0x1234]=0xA5; cpu_req READ 0x1234 -> cpu_gnt same cycle, next cycle cpu_rvalid=1, cpu_rdata=0xA5, dma_rvalid=0.
- Contention: both request at the same time, CPU write 0x0200=0x11, DMA read 0x0200 -> CPU granted first, DMA granted next cycle and returns 0x11.
- Pipelined reads: CPU reads 0x10,0x11,0x12 on consecutive cycles (mem=1,2,3) -> rvalid high 3 consecutive cycles with data 1,2,3.
- Starvation with MEM_ARB_WAIT_GUARD_EN, MAX_WAIT=4: cpu_req stays high, DMA read pending -> DMA granted on its 5th requesting cycle, CPU gnt=0 that cycle. Without the macro, DMA is never granted.
- Reset mid-read: CPU read granted, reset asserted the next cycle -> no cpu_rvalid; after release, normal grants resume.
